// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit common-anode scan driver
// Frame snapshot, lap hold, lead-zero blanking, dp.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DIV_WIDTH  = 10,
  parameter int unsigned BLANK_LEAD = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_sec_3,
  input  logic [3:0] i_sec_2,
  input  logic [3:0] i_sec_1,
  input  logic [3:0] i_sec_0,
  input  logic [3:0] i_min_1,
  input  logic [3:0] i_min_0,
  input  logic [3:0] i_hr_1,
  input  logic [3:0] i_hr_0,
  input  logic       i_lap,
  output logic [7:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic       o_hold
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST =
    DIV_WIDTH'(SCAN_DIV - 1);

  logic [DIV_WIDTH-1:0] cnt;
  logic [2:0]           idx;
  logic                 hold;
  logic [7:0][3:0]      snap;
  logic [7:0][3:0]      in_bus;
  logic                 div_wrap;
  logic                 frame_cap;
  logic [3:0]           cur;
  logic [6:0]           pat;
  logic [7:0]           blank_vec;
  logic                 zrun;
  logic                 blank_cur;
  logic                 dp_pos;
  logic                 dead;

  assign in_bus = {i_hr_0, i_hr_1,
                   i_min_0, i_min_1,
                   i_sec_0, i_sec_1,
                   i_sec_2, i_sec_3};

  assign div_wrap  = (cnt == DIV_LAST);
  assign frame_cap = ~hold & div_wrap
                   & (idx == 3'd7);
  assign dead      = (cnt == '0);
  assign o_hold    = hold;

  // Prescaler and digit index advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (div_wrap) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + DIV_WIDTH'(1);
    end
  end

  // Hold toggle and snapshot load (lap or frame end)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold <= 1'b0;
      snap <= '0;
    end else if (i_lap) begin
      hold <= ~hold;
      snap <= in_bus;
    end else if (frame_cap) begin
      snap <= in_bus;
    end
  end

  // Leading-zero run from the left edge
  always_comb begin
    zrun      = 1'b1;
    blank_vec = '0;
    for (int k = 7; k >= 0; k--) begin
      zrun = zrun & (snap[k] == 4'd0);
      if (k >= 3 && BLANK_LEAD != 0)
        blank_vec[k] = zrun;
    end
  end

  // BCD to segment pattern for current slot
  always_comb begin
    cur = snap[idx];
    pat = 7'h3F;
    case (cur)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h3F;
    endcase
  end

  assign blank_cur = blank_vec[idx];
  assign dp_pos    = ~idx[0] & (idx != 3'd0);

  // Registered display drive with dead time
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_an  <= 8'hFF;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= dead ? 8'hFF : ~(8'd1 << idx);
      o_seg <= blank_cur ? 7'h7F : pat;
      o_dp  <= ~(~dead & dp_pos & ~blank_cur);
    end
  end

endmodule
